bram_port_arbiter: RTL and testbench

- Shares one native port of the 256 KB dual-port data BRAM (32-bit words, 4 byte-write enables, 1-cycle read latency) between two requesters, e.g. instruction fetch (req0) and load/store unit (req1).
- Round-robin arbitration with a valid/ready request handshake and a fixed-latency response.
- Converts byte addresses to word addresses and rejects out-of-range or misaligned requests without touching the BRAM.
- Sits between the core-side requesters and the BRAM A (or B) port.

---
 rtl/bram_port_arbiter.sv | 131 +++++++++++++
 tb/tb_bram_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bram_port_arbiter
//  Purpose  : Shares one native port of the 256 KB data BRAM (32-bit words,
//             4 byte enables, 1-cycle read latency) between two requesters
//             using round-robin arbitration. Byte addresses are converted to
//             word addresses. Misaligned or out-of-range requests are
//             answered with an error response and never reach the BRAM.
//  Ports    : clka/rsta           clock, synchronous active-high reset
//             req{0,1}_*          valid/ready request channel (we, addr, wdata)
//             rsp{0,1}_*          fixed-latency response (valid, rdata, err)
//             bram_*              native BRAM port (en, we, addr, din, dout)
//             err_count           saturating count of rejected requests
//  Revision : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clka,
  input  logic                 rsta,
  // requester 0
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [3:0]           req0_we,
  input  logic [31:0]          req0_addr,
  input  logic [31:0]          req0_wdata,
  output logic                 rsp0_valid,
  output logic [31:0]          rsp0_rdata,
  output logic                 rsp0_err,
  // requester 1
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [3:0]           req1_we,
  input  logic [31:0]          req1_addr,
  input  logic [31:0]          req1_wdata,
  output logic                 rsp1_valid,
  output logic [31:0]          rsp1_rdata,
  output logic                 rsp1_err,
  // BRAM port
  output logic                 bram_en,
  output logic [3:0]           bram_we,
  output logic [ADDR_W-1:0]    bram_addr,
  output logic [31:0]          bram_din,
  input  logic [31:0]          bram_dout,
  // status
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [ERR_CNT_W-1:0] c_err_max = '1;

  // Arbitration state and registered response control
  logic                 r_last_grant;
  logic                 r_rsp_valid;
  logic                 r_rsp_sel;
  logic                 r_rsp_rd;
  logic                 r_rsp_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  // Combinational grant path
  logic        w_grant;
  logic        w_sel;
  logic [3:0]  w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;
  logic        w_legal;

  // No grant is issued while reset is held.
  assign w_grant = !rsta && (req0_valid || req1_valid);

  // Under contention the requester that did not win last time is chosen.
  always_comb begin
    if (req0_valid && req1_valid) begin
      w_sel = ~r_last_grant;
    end else begin
      w_sel = req1_valid;
    end
  end

  assign w_we    = w_sel ? req1_we    : req0_we;
  assign w_addr  = w_sel ? req1_addr  : req0_addr;
  assign w_wdata = w_sel ? req1_wdata : req0_wdata;

  // Reject word-misaligned addresses and anything beyond the BRAM size.
  assign w_err   = (w_addr[1:0] != 2'b00) || (w_addr[31:ADDR_W+2] != '0);
  assign w_legal = w_grant && !w_err;

  assign req0_ready = w_grant && !w_sel;
  assign req1_ready = w_grant &&  w_sel;

  assign bram_en   = w_legal;
  assign bram_we   = w_legal ? w_we : 4'b0000;
  assign bram_addr = w_addr[ADDR_W+1:2];
  assign bram_din  = w_wdata;

  always_ff @(posedge clka) begin
    if (rsta) begin
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_sel    <= 1'b0;
      r_rsp_rd     <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_rsp_valid <= w_grant;
      r_rsp_sel   <= w_sel;
      r_rsp_rd    <= w_legal && (w_we == 4'b0000);
      r_rsp_err   <= w_grant && w_err;
      if (w_grant) begin
        r_last_grant <= w_sel;
      end
      if (w_grant && w_err && (r_err_count != c_err_max)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  // A response whose cycle coincides with reset is suppressed; the BRAM
  // read data is only forwarded for legal reads so writes/errors return 0.
  assign rsp0_valid = r_rsp_valid && !r_rsp_sel && !rsta;
  assign rsp1_valid = r_rsp_valid &&  r_rsp_sel && !rsta;
  assign rsp0_err   = rsp0_valid && r_rsp_err;
  assign rsp1_err   = rsp1_valid && r_rsp_err;
  assign rsp0_rdata = (rsp0_valid && r_rsp_rd) ? bram_dout : 32'h0;
  assign rsp1_rdata = (rsp1_valid && r_rsp_rd) ? bram_dout : 32'h0;

  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_port_arbiter
//  Purpose  : Directed self-checking bench for bram_port_arbiter with a
//             behavioural 1-cycle-latency byte-writable BRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

  localparam int ADDR_W    = 16;
  localparam int ERR_CNT_W = 8;

  logic                 clk = 1'b0;
  logic                 rsta;
  logic                 req0_valid, req0_ready;
  logic [3:0]           req0_we;
  logic [31:0]          req0_addr, req0_wdata;
  logic                 rsp0_valid, rsp0_err;
  logic [31:0]          rsp0_rdata;
  logic                 req1_valid, req1_ready;
  logic [3:0]           req1_we;
  logic [31:0]          req1_addr, req1_wdata;
  logic                 rsp1_valid, rsp1_err;
  logic [31:0]          rsp1_rdata;
  logic                 bram_en;
  logic [3:0]           bram_we;
  logic [ADDR_W-1:0]    bram_addr;
  logic [31:0]          bram_din;
  logic [31:0]          bram_dout;
  logic [ERR_CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  bram_port_arbiter #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) dut (
    .clka       (clk),
    .rsta       (rsta),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .rsp0_err   (rsp0_err),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .rsp1_err   (rsp1_err),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_dout  (bram_dout),
    .err_count  (err_count)
  );

  // BRAM model: read-first, byte-writable, data out one cycle after enable.
  initial begin
    for (int k = 0; k < (1<<ADDR_W); k++) mem[k] = 32'h0;
    mem[16'h0000] = 32'h5A5A5A5A;
    mem[16'h0010] = 32'hDEADBEEF;
    mem[16'h0040] = 32'h11223344;
    bram_dout = 32'h0;
    forever begin
      @(posedge clk);
      if (bram_en) begin
        bram_dout <= mem[bram_addr];
        for (int b = 0; b < 4; b++) begin
          if (bram_we[b]) mem[bram_addr][8*b +: 8] = bram_din[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rsta = 1'b1;
    req0_valid = 1'b1; req0_we = 4'h0; req0_addr = 32'h40;  req0_wdata = 32'h0;
    req1_valid = 1'b1; req1_we = 4'h0; req1_addr = 32'h100; req1_wdata = 32'h0;

    // ---------------- reset state ----------------
    tick;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_bram_en",    bram_en,    0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_rdata", rsp0_rdata, 0);
    chk("rst_err_count",  err_count,  0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsta = 1'b0;
    tick;

    // ---------------- single read ----------------
    req0_valid = 1'b1; req0_we = 4'h0; req0_addr = 32'h40;
    #1;
    chk("rd_req0_ready", req0_ready, 1);
    chk("rd_req1_ready", req1_ready, 0);
    chk("rd_bram_en",    bram_en,    1);
    chk("rd_bram_we",    bram_we,    0);
    chk("rd_bram_addr",  bram_addr,  32'h10);
    tick;
    req0_valid = 1'b0;
    #1;
    chk("rd_rsp0_valid", rsp0_valid, 1);
    chk("rd_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
    chk("rd_rsp0_err",   rsp0_err,   0);
    chk("rd_rsp1_valid", rsp1_valid, 0);
    tick;
    chk("rd_rsp0_once",  rsp0_valid, 0);

    // ---------------- byte write then read ----------------
    req1_valid = 1'b1; req1_we = 4'b0010; req1_addr = 32'h100; req1_wdata = 32'h0000AB00;
    #1;
    chk("wr_req1_ready", req1_ready, 1);
    chk("wr_bram_we",    bram_we,    4'b0010);
    chk("wr_bram_addr",  bram_addr,  32'h40);
    chk("wr_bram_din",   bram_din,   32'h0000AB00);
    tick;
    req1_we = 4'h0;
    #1;
    chk("wr_rsp1_valid", rsp1_valid, 1);
    chk("wr_rsp1_err",   rsp1_err,   0);
    chk("wr_rsp1_rdata", rsp1_rdata, 0);
    tick;
    req1_valid = 1'b0;
    #1;
    chk("wrrd_rsp1_valid", rsp1_valid, 1);
    chk("wrrd_rsp1_rdata", rsp1_rdata, 32'h1122AB44);
    tick;

    // ---------------- contention right after reset ----------------
    rsta = 1'b1;
    tick;
    rsta = 1'b0;
    req0_valid = 1'b1; req0_we = 4'h0; req0_addr = 32'h40;
    req1_valid = 1'b1; req1_we = 4'h0; req1_addr = 32'h100;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("cont_req0_ready", req0_ready, (i % 2 == 0));
      chk("cont_req1_ready", req1_ready, (i % 2 == 1));
      if (i > 0) begin
        chk("cont_rsp0_valid", rsp0_valid, ((i - 1) % 2 == 0));
        chk("cont_rsp1_valid", rsp1_valid, ((i - 1) % 2 == 1));
        if ((i - 1) % 2 == 0) chk("cont_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
        else                  chk("cont_rsp1_rdata", rsp1_rdata, 32'h1122AB44);
      end
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("cont_last_rsp1_valid", rsp1_valid, 1);
    chk("cont_last_rsp1_rdata", rsp1_rdata, 32'h1122AB44);
    chk("cont_last_rsp0_valid", rsp0_valid, 0);
    tick;

    // ---------------- error responses ----------------
    req0_valid = 1'b1; req0_we = 4'hF; req0_addr = 32'h00040000; req0_wdata = 32'hFFFFFFFF;
    #1;
    chk("err0_req0_ready", req0_ready, 1);
    chk("err0_bram_en",    bram_en,    0);
    chk("err0_bram_we",    bram_we,    0);
    tick;
    req0_valid = 1'b0; req0_we = 4'h0;
    req1_valid = 1'b1; req1_we = 4'h0; req1_addr = 32'h00000002;
    #1;
    chk("err1_req1_ready", req1_ready, 1);
    chk("err1_bram_en",    bram_en,    0);
    chk("err0_rsp0_valid", rsp0_valid, 1);
    chk("err0_rsp0_err",   rsp0_err,   1);
    chk("err0_rsp0_rdata", rsp0_rdata, 0);
    tick;
    req1_valid = 1'b0;
    #1;
    chk("err1_rsp1_valid", rsp1_valid, 1);
    chk("err1_rsp1_err",   rsp1_err,   1);
    chk("err1_rsp1_rdata", rsp1_rdata, 0);
    chk("err_count_2",     err_count,  2);
    chk("err_no_bram_wr",  mem[0],     32'h5A5A5A5A);

    req0_valid = 1'b1; req0_addr = 32'h00000001;
    repeat (298) tick;
    req0_valid = 1'b0; req0_addr = 32'h40;
    #1;
    chk("err_count_sat", err_count, 255);
    tick;

    // ---------------- stall ----------------
    req1_valid = 1'b1; req1_we = 4'h0; req1_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req1_ready", req1_ready, 1);
      chk("stall_req0_ready", req0_ready, 0);
      tick;
    end
    req0_valid = 1'b1; req0_we = 4'h0; req0_addr = 32'h40;
    #1;
    chk("stall_both_req0_ready", req0_ready, 1);
    chk("stall_both_req1_ready", req1_ready, 0);
    chk("stall_both_bram_addr",  bram_addr,  32'h10);
    chk("stall_prev_rsp1_valid", rsp1_valid, 1);
    tick;
    req0_valid = 1'b0;
    #1;
    chk("stall_held_req1_ready", req1_ready, 1);
    chk("stall_held_bram_addr",  bram_addr,  32'h40);
    chk("stall_rsp0_valid",      rsp0_valid, 1);
    chk("stall_rsp0_rdata",      rsp0_rdata, 32'hDEADBEEF);
    tick;
    req1_valid = 1'b0;
    #1;
    chk("stall_rsp1_valid", rsp1_valid, 1);
    chk("stall_rsp1_rdata", rsp1_rdata, 32'h1122AB44);
    tick;

    // ---------------- reset in the response cycle ----------------
    req0_valid = 1'b1; req0_addr = 32'h40;
    #1;
    chk("rmid_req0_ready", req0_ready, 1);
    tick;
    req0_valid = 1'b0;
    rsta = 1'b1;
    #1;
    chk("rmid_rsp0_valid", rsp0_valid, 0);
    chk("rmid_rsp0_rdata", rsp0_rdata, 0);
    chk("rmid_req1_ready", req1_ready, 0);
    tick;
    rsta = 1'b0;
    #1;
    chk("rmid_rsp0_after", rsp0_valid, 0);
    chk("rmid_err_count",  err_count,  0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rmid_first_req0_ready", req0_ready, 1);
    chk("rmid_first_req1_ready", req1_ready, 0);
    tick;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
